pusch_hop_seq_gen: RTL

Generates the pseudo-random Gold-sequence bits c(n) (TS 38.211 §5.2.1) that drive PUSCH DMRS group and sequence hopping for one OFDM symbol. It sits upstream of the parameter generator: it takes cell/slot/symbol context, computes c_init, advances the LFSR pair to the required index and delivers the 8-bit `c` word that the generator reduces to `u`/`v`. It is the producer end of that `c` interface. Output is one registered word per request with a start/valid handshake.

---
 rtl/pusch_pkg.sv | 20 ++
 rtl/gold_lfsr.sv | 37 +++
 rtl/pusch_hop_seq_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pusch_pkg.sv
// rtl/pusch_pkg.sv - shared constants, hopping mode codes and FSM states for the PUSCH hop sequence generator
package pusch_pkg;

    localparam int NC          = 1600;  // Gold-sequence offset Nc
    localparam int N_SYMB_SLOT = 14;    // OFDM symbols per slot
    localparam int CNT_W       = 15;    // skip counter width, max N = 30264

    localparam logic [1:0] HOP_DIS = 2'd0;
    localparam logic [1:0] HOP_GH  = 2'd1;
    localparam logic [1:0] HOP_SH  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SKIP,
        ST_COLLECT,
        ST_DONE
    } hop_state_t;

endpackage

// File: rtl/gold_lfsr.sv
// rtl/gold_lfsr.sv - x1/x2 LFSR pair of the length-31 Gold sequence generator
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears x1/x2)
//   i_load        : x1 <= 1, x2 <= c_init
//   i_c_init      : 31-bit x2 initial state
//   i_step        : advance both registers by one position
//   o_out_bit     : current sequence bit x1(n) ^ x2(n)
module gold_lfsr (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [30:0] i_c_init,
    input  logic        i_step,
    output logic        o_out_bit
);

    logic [30:0] r_x1;
    logic [30:0] r_x2;

    // Bit 0 holds x(n); each step shifts down and inserts x(n+31) at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x1 <= '0;
            r_x2 <= '0;
        end else if (i_load) begin
            r_x1 <= 31'd1;
            r_x2 <= i_c_init;
        end else if (i_step) begin
            r_x1 <= {r_x1[3] ^ r_x1[0], r_x1[30:1]};
            r_x2 <= {r_x2[3] ^ r_x2[2] ^ r_x2[1] ^ r_x2[0], r_x2[30:1]};
        end
    end

    assign o_out_bit = r_x1[0] ^ r_x2[0];

endmodule

// File: rtl/pusch_hop_seq_gen.sv
// rtl/pusch_hop_seq_gen.sv - Gold-sequence c word producer for PUSCH DMRS group/sequence hopping
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : request pulse, accepted only in IDLE
//   n_ID        : DMRS scrambling ID 0..1023
//   En_hopping  : 0/3 disabled, 1 group hopping, 2 sequence hopping
//   n_s, l      : slot number in frame, symbol index in slot
//   c           : result word, c[m] = c(base+m), held until the next c_valid
//   c_valid     : one-cycle pulse when c is updated
//   busy        : high from the accepting edge until the edge raising c_valid
module pusch_hop_seq_gen
    import pusch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] n_ID,
    input  logic [1:0] En_hopping,
    input  logic [7:0] n_s,
    input  logic [3:0] l,
    output logic [7:0] c,
    output logic       c_valid,
    output logic       busy
);

    hop_state_t       r_state;
    logic [30:0]      r_cinit;
    logic [CNT_W-1:0] r_cnt;
    logic             r_gh;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;

    logic             w_mode_gh;
    logic             w_mode_sh;
    logic [5:0]       w_gh_cinit;
    logic [11:0]      w_sym_idx;
    logic [14:0]      w_base;
    logic [CNT_W-1:0] w_skip;
    logic [30:0]      w_cinit;
    logic             w_lfsr_load;
    logic             w_lfsr_step;
    logic             w_out_bit;
    logic [7:0]       w_shift_next;
    logic             w_last_bit;

    assign w_mode_gh = (En_hopping == HOP_GH);
    assign w_mode_sh = (En_hopping == HOP_SH);

    // floor(n_ID/30) as (n_ID * 1093) >> 15: the reciprocal error stays below
    // 1/30 across 0..1023, so the quotient is exact over the whole input range.
    assign w_gh_cinit = 6'(({11'd0, n_ID} * 21'd1093) >> 15);

    assign w_sym_idx = 12'(n_s) * 12'(N_SYMB_SLOT) + 12'(l);
    assign w_base    = w_mode_gh ? {w_sym_idx, 3'b000} : {3'b000, w_sym_idx};
    assign w_skip    = CNT_W'(NC) + w_base;
    assign w_cinit   = w_mode_gh ? 31'(w_gh_cinit) : 31'(n_ID);

    assign w_lfsr_load = (r_state == ST_LOAD);
    assign w_lfsr_step = (r_state == ST_SKIP) || (r_state == ST_COLLECT);

    assign w_shift_next = r_shift | (8'(w_out_bit) << r_bit_idx);
    assign w_last_bit   = r_gh ? (r_bit_idx == 3'd7) : 1'b1;

    gold_lfsr u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_lfsr_load),
        .i_c_init  (r_cinit),
        .i_step    (w_lfsr_step),
        .o_out_bit (w_out_bit)
    );

    // Enabled requests finish directly from the last COLLECT edge into IDLE so
    // that the c_valid cycle can already accept the next start; DONE is only
    // visited by disabled requests, which produce a fixed zero word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cinit   <= '0;
            r_cnt     <= '0;
            r_gh      <= 1'b0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            c         <= '0;
            c_valid   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            c_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        r_cinit <= w_cinit;
                        r_cnt   <= w_skip;
                        r_gh    <= w_mode_gh;
                        r_state <= (w_mode_gh || w_mode_sh) ? ST_LOAD : ST_DONE;
                    end
                end
                ST_LOAD: begin
                    r_shift   <= '0;
                    r_bit_idx <= '0;
                    r_state   <= ST_SKIP;
                end
                ST_SKIP: begin
                    // The edge that takes cnt from 1 to 0 is the Nth step.
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    r_shift   <= w_shift_next;
                    r_bit_idx <= r_bit_idx + 3'd1;
                    if (w_last_bit) begin
                        c       <= w_shift_next;
                        c_valid <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    c       <= '0;
                    c_valid <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
